// File: rtl/cacheline_adapter_pkg.sv
// Shared constants and state type for the cache line <-> burst memory adapter.
// A line is split into BEATS beats of BEAT_BITS each, lowest beat first.
package cacheline_adapter_pkg;

    localparam int unsigned LINE_BITS   = 256;
    localparam int unsigned BEAT_BITS   = 64;
    localparam int unsigned BEATS       = LINE_BITS / BEAT_BITS;
    localparam int unsigned CNT_BITS    = $clog2(BEATS);
    localparam int unsigned ADDR_BITS   = 32;
    localparam int unsigned OFFSET_BITS = $clog2(LINE_BITS / 8);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrBurst,
        StDone
    } adapter_state_t;

    // Clear the byte offset within a line.
    function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] addr);
        return {addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Memory-side responder for one cache: turns a 256-bit line read/write into a 64-bit burst
// on the memory port and answers with a one-cycle dfp_resp. All outputs are registered.
module cacheline_adapter
    import cacheline_adapter_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [ADDR_BITS-1:0] i_dfp_addr,
    input  logic                 i_dfp_read,
    input  logic                 i_dfp_write,
    input  logic [LINE_BITS-1:0] i_dfp_wdata,
    output logic [LINE_BITS-1:0] o_dfp_rdata,
    output logic                 o_dfp_resp,
    input  logic                 i_bmem_ready,
    output logic [ADDR_BITS-1:0] o_bmem_addr,
    output logic                 o_bmem_read,
    output logic                 o_bmem_write,
    output logic [BEAT_BITS-1:0] o_bmem_wdata,
    input  logic [ADDR_BITS-1:0] i_bmem_raddr,
    input  logic [BEAT_BITS-1:0] i_bmem_rdata,
    input  logic                 i_bmem_rvalid
);

    adapter_state_t       r_state;
    logic [CNT_BITS-1:0]  r_cnt;
    logic [LINE_BITS-1:0] r_buf;
    logic [ADDR_BITS-1:0] r_addr;
    logic [LINE_BITS-1:0] r_dfp_rdata;
    logic                 r_dfp_resp;
    logic                 r_bmem_read;
    logic                 r_bmem_write;
    logic [BEAT_BITS-1:0] r_bmem_wdata;

    logic                 w_last;
    logic                 w_rd_hit;
    logic [CNT_BITS-1:0]  w_cnt_nxt;
    logic [LINE_BITS-1:0] w_buf_merged;
    logic [BEAT_BITS-1:0] w_next_wbeat;

    assign w_last    = (r_cnt == CNT_BITS'(BEATS - 1));
    assign w_rd_hit  = i_bmem_rvalid && (i_bmem_raddr == r_addr);
    assign w_cnt_nxt = r_cnt + 1'b1;

    // Line buffer with the incoming read beat dropped into its slot, so the final beat can be
    // forwarded to dfp_rdata in the same edge that stores it.
    always_comb begin
        w_buf_merged = r_buf;
        w_buf_merged[BEAT_BITS*r_cnt +: BEAT_BITS] = i_bmem_rdata;
    end

    assign w_next_wbeat = r_buf[BEAT_BITS*w_cnt_nxt +: BEAT_BITS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_buf        <= '0;
            r_addr       <= '0;
            r_dfp_rdata  <= '0;
            r_dfp_resp   <= 1'b0;
            r_bmem_read  <= 1'b0;
            r_bmem_write <= 1'b0;
            r_bmem_wdata <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_dfp_write) begin
                        r_addr       <= line_align(i_dfp_addr);
                        r_buf        <= i_dfp_wdata;
                        r_cnt        <= '0;
                        r_bmem_write <= 1'b1;
                        r_bmem_wdata <= i_dfp_wdata[BEAT_BITS-1:0];
                        r_state      <= StWrBurst;
                    end else if (i_dfp_read) begin
                        r_addr      <= line_align(i_dfp_addr);
                        r_cnt       <= '0;
                        r_bmem_read <= 1'b1;
                        r_state     <= StRdReq;
                    end
                end
                StRdReq: begin
                    if (i_bmem_ready) begin
                        r_bmem_read <= 1'b0;
                        r_state     <= StRdWait;
                    end
                end
                StRdWait: begin
                    // Beats tagged for another address are not ours and are dropped.
                    if (w_rd_hit) begin
                        r_buf <= w_buf_merged;
                        r_cnt <= w_cnt_nxt;
                        if (w_last) begin
                            r_dfp_rdata <= w_buf_merged;
                            r_dfp_resp  <= 1'b1;
                            r_state     <= StDone;
                        end
                    end
                end
                StWrBurst: begin
                    if (i_bmem_ready) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_last) begin
                            r_bmem_write <= 1'b0;
                            r_bmem_wdata <= '0;
                            r_dfp_rdata  <= r_buf;
                            r_dfp_resp   <= 1'b1;
                            r_state      <= StDone;
                        end else begin
                            r_bmem_wdata <= w_next_wbeat;
                        end
                    end
                end
                StDone: begin
                    r_dfp_resp  <= 1'b0;
                    r_dfp_rdata <= '0;
                    r_state     <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_dfp_rdata  = r_dfp_rdata;
    assign o_dfp_resp   = r_dfp_resp;
    assign o_bmem_addr  = r_addr;
    assign o_bmem_read  = r_bmem_read;
    assign o_bmem_write = r_bmem_write;
    assign o_bmem_wdata = r_bmem_wdata;

    // Protocol observations: these never change behaviour, they only report.
    always @(posedge i_clk) begin
        if (!i_rst && r_state == StIdle) begin
            assert (!(i_dfp_read && i_dfp_write))
            else $warning("cacheline_adapter: read and write requested together, write taken");
        end
        if (!i_rst && r_state == StRdWait && i_bmem_rvalid) begin
            assert (i_bmem_raddr == r_addr)
            else $warning("cacheline_adapter: beat for 0x%08h dropped, burst is 0x%08h",
                          i_bmem_raddr, r_addr);
        end
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: writes with and without stalls, gapped reads, stray
// beats, writeback-then-allocate and reset mid-burst, against hand-computed expectations.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic         bmem_ready;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    always #5 clk = ~clk;

    cacheline_adapter u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_dfp_addr   (dfp_addr),
        .i_dfp_read   (dfp_read),
        .i_dfp_write  (dfp_write),
        .i_dfp_wdata  (dfp_wdata),
        .o_dfp_rdata  (dfp_rdata),
        .o_dfp_resp   (dfp_resp),
        .i_bmem_ready (bmem_ready),
        .o_bmem_addr  (bmem_addr),
        .o_bmem_read  (bmem_read),
        .o_bmem_write (bmem_write),
        .o_bmem_wdata (bmem_wdata),
        .i_bmem_raddr (bmem_raddr),
        .i_bmem_rdata (bmem_rdata),
        .i_bmem_rvalid(bmem_rvalid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observations gathered by the transaction drivers.
    logic [63:0]  beats [8];
    int           n_beats;
    int           resp_cyc;
    int           n_resp;
    int           n_rd_cmd;
    int           cmd_cyc;
    logic         held_ok;
    logic         overlap;
    logic [31:0]  addr_seen;
    logic [255:0] rdata_seen;

    localparam logic [255:0] LINE_A = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                                       64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    localparam logic [255:0] LINE_B = {64'hB3B3_1111_2222_3333, 64'hB2B2_4444_5555_6666,
                                       64'hB1B1_7777_8888_9999, 64'hB0B0_AAAA_BBBB_CCCC};
    localparam logic [255:0] LINE_D = {64'hD3D3_D3D3_0000_0033, 64'hD2D2_D2D2_0000_0022,
                                       64'hD1D1_D1D1_0000_0011, 64'hD0D0_D0D0_0000_0000};
    localparam logic [255:0] LINE_E = {64'hE3E3_0123_4567_89AB, 64'hE2E2_CDEF_0123_4567,
                                       64'hE1E1_89AB_CDEF_0123, 64'hE0E0_4567_89AB_CDEF};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one line write; cycle c is the c-th cycle after the request is raised.
    // stall_mask[c] holds ready low in cycle c. Returns tail cycles after the resp cycle.
    task automatic do_write(input logic [31:0] addr, input logic [255:0] wd,
                            input logic [63:0] stall_mask, input int tail);
        logic        prev_stall;
        logic [63:0] prev_wd;
        n_beats = 0; resp_cyc = -1; n_resp = 0; held_ok = 1'b1; overlap = 1'b0;
        prev_stall = 1'b0; prev_wd = '0; addr_seen = '0;
        dfp_addr = addr; dfp_wdata = wd; dfp_read = 1'b0; dfp_write = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            bmem_ready = !stall_mask[c];
            if (prev_stall && (bmem_write !== 1'b1 || bmem_wdata !== prev_wd)) held_ok = 1'b0;
            prev_stall = bmem_write && !bmem_ready;
            prev_wd    = bmem_wdata;
            if (bmem_write && bmem_read) overlap = 1'b1;
            if (bmem_write === 1'b1 && bmem_ready) begin
                if (n_beats == 0) addr_seen = bmem_addr;
                if (n_beats < 8) beats[n_beats] = bmem_wdata;
                n_beats++;
            end
            if (dfp_resp === 1'b1) begin
                n_resp++;
                if (resp_cyc < 0) begin
                    resp_cyc  = c;
                    dfp_write = 1'b0;
                end
            end
            if (resp_cyc >= 0 && c >= resp_cyc + tail) break;
        end
        bmem_ready = 1'b1;
    endtask

    // Drives one line read; memory answers with beats `gap` idle cycles apart, optionally
    // slipping a beat for another address into the gap after the second beat.
    task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input int gap,
                           input bit stray, input int tail);
        int k;
        int r;
        n_rd_cmd = 0; cmd_cyc = -1; resp_cyc = -1; n_resp = 0; overlap = 1'b0; k = 0;
        addr_seen = '0; rdata_seen = '0;
        dfp_addr = addr; dfp_write = 1'b0; dfp_read = 1'b1; bmem_ready = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
            if (bmem_write && bmem_read) overlap = 1'b1;
            if (bmem_read === 1'b1) begin
                n_rd_cmd++;
                cmd_cyc   = c;
                addr_seen = bmem_addr;
            end else if (cmd_cyc >= 0 && k < 4) begin
                r = c - cmd_cyc - 1;
                if (r % (gap + 1) == 0) begin
                    bmem_rvalid = 1'b1;
                    bmem_raddr  = {addr[31:5], 5'b0};
                    bmem_rdata  = line[64*k +: 64];
                    k++;
                end else if (stray && k == 2 && r % (gap + 1) == 1) begin
                    bmem_rvalid = 1'b1;
                    bmem_raddr  = 32'h0000_0080;
                    bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
                end
            end
            if (dfp_resp === 1'b1) begin
                n_resp++;
                if (resp_cyc < 0) begin
                    resp_cyc   = c;
                    rdata_seen = dfp_rdata;
                    dfp_read   = 1'b0;
                end
            end
            if (resp_cyc >= 0 && c >= resp_cyc + tail) break;
        end
        bmem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({dfp_resp, bmem_read, bmem_write} !== 3'b000)
            $display("FAIL reset_strobes: got %b want 000", {dfp_resp, bmem_read, bmem_write});
        else n_pass++;
        n_checks++;
        if (dfp_rdata !== '0 || bmem_addr !== '0 || bmem_wdata !== '0)
            $display("FAIL reset_data: rdata %h addr %h wdata %h want all 0",
                     dfp_rdata, bmem_addr, bmem_wdata);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_basic();
        do_write(32'h1234_5678, LINE_A, 64'h0, 1);
        n_checks++;
        if (addr_seen !== 32'h1234_5660)
            $display("FAIL w1_addr: got %h want 12345660", addr_seen);
        else n_pass++;
        n_checks++;
        if (n_beats !== 4) $display("FAIL w1_beat_count: got %0d want 4", n_beats);
        else n_pass++;
        n_checks++;
        if ({beats[3], beats[2], beats[1], beats[0]} !== LINE_A)
            $display("FAIL w1_beat_order: got %h %h %h %h want A0..A3",
                     beats[0], beats[1], beats[2], beats[3]);
        else n_pass++;
        // Request raised in cycle 0, beats in cycles 1-4, resp in cycle 5: six cycles in all.
        n_checks++;
        if (resp_cyc !== 5) $display("FAIL w1_resp_cycle: got %0d want 5", resp_cyc);
        else n_pass++;
        n_checks++;
        if (n_resp !== 1) $display("FAIL w1_resp_pulse: got %0d cycles want 1", n_resp);
        else n_pass++;
    endtask

    task automatic test_write_stall();
        // Beats 0,1 in cycles 1,2; ready low in 3,4; beat 2 taken in 5, beat 3 in 6.
        do_write(32'h0000_2000, LINE_B, 64'h18, 1);
        n_checks++;
        if (n_beats !== 4) $display("FAIL w2_beat_count: got %0d want 4", n_beats);
        else n_pass++;
        n_checks++;
        if ({beats[3], beats[2], beats[1], beats[0]} !== LINE_B)
            $display("FAIL w2_beat_order: got %h %h %h %h", beats[0], beats[1], beats[2], beats[3]);
        else n_pass++;
        n_checks++;
        if (held_ok !== 1'b1) $display("FAIL w2_hold: got %b want 1", held_ok);
        else n_pass++;
        n_checks++;
        if (resp_cyc !== 7) $display("FAIL w2_resp_cycle: got %0d want 7", resp_cyc);
        else n_pass++;
    endtask

    task automatic test_read_gaps();
        // Cmd in cycle 1, beats in 2,4,6,8, resp in 9.
        do_read(32'h0000_0040, LINE_D, 1, 1'b0, 1);
        n_checks++;
        if (n_rd_cmd !== 1) $display("FAIL r3_cmd_count: got %0d want 1", n_rd_cmd);
        else n_pass++;
        n_checks++;
        if (addr_seen !== 32'h0000_0040) $display("FAIL r3_addr: got %h want 00000040", addr_seen);
        else n_pass++;
        n_checks++;
        if (rdata_seen !== LINE_D) $display("FAIL r3_rdata: got %h want %h", rdata_seen, LINE_D);
        else n_pass++;
        n_checks++;
        if (resp_cyc !== 9) $display("FAIL r3_resp_cycle: got %0d want 9", resp_cyc);
        else n_pass++;
        n_checks++;
        if (n_resp !== 1) $display("FAIL r3_resp_pulse: got %0d cycles want 1", n_resp);
        else n_pass++;
    endtask

    task automatic test_read_stray();
        do_read(32'h0000_0040, LINE_E, 1, 1'b1, 1);
        n_checks++;
        if (rdata_seen !== LINE_E) $display("FAIL r4_rdata: got %h want %h", rdata_seen, LINE_E);
        else n_pass++;
        n_checks++;
        if (resp_cyc !== 9) $display("FAIL r4_resp_cycle: got %0d want 9", resp_cyc);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_write(32'h0000_0500, LINE_A, 64'h0, 0);
        n_checks++;
        if (resp_cyc !== 5) $display("FAIL b2b_wr_resp_cycle: got %0d want 5", resp_cyc);
        else n_pass++;
        n_checks++;
        if (overlap !== 1'b0) $display("FAIL b2b_wr_overlap: got %b want 0", overlap);
        else n_pass++;
        // Read raised during the write's resp cycle: accepted in cycle 1, cmd in 2,
        // beats 3-6, resp in 7.
        do_read(32'h0000_0C1F, LINE_B, 0, 1'b0, 1);
        n_checks++;
        if (cmd_cyc !== 2) $display("FAIL b2b_rd_cmd_cycle: got %0d want 2", cmd_cyc);
        else n_pass++;
        n_checks++;
        if (addr_seen !== 32'h0000_0C00) $display("FAIL b2b_rd_addr: got %h want 00000c00", addr_seen);
        else n_pass++;
        n_checks++;
        if (rdata_seen !== LINE_B) $display("FAIL b2b_rd_rdata: got %h want %h", rdata_seen, LINE_B);
        else n_pass++;
        n_checks++;
        if (resp_cyc !== 7) $display("FAIL b2b_rd_resp_cycle: got %0d want 7", resp_cyc);
        else n_pass++;
        n_checks++;
        if (overlap !== 1'b0) $display("FAIL b2b_rd_overlap: got %b want 0", overlap);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] a;
        a = 32'h0000_0100;
        dfp_addr = a; dfp_write = 1'b0; dfp_read = 1'b1; bmem_ready = 1'b1;
        tick();  // cycle 1: read command
        for (int k = 0; k < 3; k++) begin
            tick();
            bmem_rvalid = 1'b1; bmem_raddr = a; bmem_rdata = LINE_D[64*k +: 64];
        end
        tick();
        bmem_rvalid = 1'b0; dfp_read = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({dfp_resp, bmem_read, bmem_write} !== 3'b000)
            $display("FAIL rst6_strobes: got %b want 000", {dfp_resp, bmem_read, bmem_write});
        else n_pass++;
        n_checks++;
        if (dfp_rdata !== '0 || bmem_addr !== '0 || bmem_wdata !== '0)
            $display("FAIL rst6_data: rdata %h addr %h wdata %h want all 0",
                     dfp_rdata, bmem_addr, bmem_wdata);
        else n_pass++;
        tick();
        n_checks++;
        if (dfp_resp !== 1'b0) $display("FAIL rst6_no_resp: got %b want 0", dfp_resp);
        else n_pass++;
        do_read(32'h0000_0100, LINE_E, 0, 1'b0, 1);
        n_checks++;
        if (rdata_seen !== LINE_E) $display("FAIL rst6_rd_rdata: got %h want %h", rdata_seen, LINE_E);
        else n_pass++;
        n_checks++;
        if (resp_cyc !== 6) $display("FAIL rst6_rd_resp_cycle: got %0d want 6", resp_cyc);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        test_reset();
        test_write_basic();
        tick();
        test_write_stall();
        tick();
        test_read_gaps();
        tick();
        test_read_stray();
        tick();
        test_back_to_back();
        tick();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
